// File: rtl/lcg_random_generator_if.sv
// Enable/output bundle for the LCG random generator.
// The consumer drives enable and reads the random value; the generator is the slave.
interface lcg_random_generator_if #(
  parameter int unsigned width_output = 8
);

  logic                    enable;
  logic [width_output-1:0] out;

  modport master (output enable, input out);
  modport slave  (input enable, output out);

endinterface

// File: rtl/lcg_random_generator.sv
// Linear congruential pseudo-random generator: state <= A*state + C mod 2^width_state.
// The upper width_output bits of the state are presented combinationally as the random value.
module lcg_random_generator #(
  parameter int unsigned seed         = 0,
  parameter int unsigned variant      = 0,
  parameter int unsigned width_state  = 18,
  parameter int unsigned width_output = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  lcg_random_generator_if.slave  bus
);

  // Unknown variants fall back to the first (A, C) pair.
  localparam logic [31:0] a_full = (variant == 1) ? 32'd1664525  :
                                   (variant == 2) ? 32'd22695477 :
                                   (variant == 3) ? 32'd214013   :
                                                    32'd1103515245;
  localparam logic [31:0] c_full = (variant == 1) ? 32'd1013904223 :
                                   (variant == 2) ? 32'd1          :
                                   (variant == 3) ? 32'd2531011    :
                                                    32'd12345;
  localparam logic [31:0] seed_full = 32'(seed);

  localparam logic [width_state-1:0] a_value    = a_full[width_state-1:0];
  localparam logic [width_state-1:0] c_value    = c_full[width_state-1:0];
  localparam logic [width_state-1:0] seed_value = seed_full[width_state-1:0];

  logic [width_state-1:0] state;
  logic [width_state-1:0] next_state;

  // Product and sum are both sized to the state, so the modulus is plain wrap-around.
  always_comb begin
    next_state = state * a_value + c_value;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= seed_value;
    end else if (bus.enable) begin
      state <= next_state;
    end
  end

  assign bus.out = state[width_state-1 -: width_output];

endmodule

// File: tb/tb_lcg_random_generator.sv
// Self-checking bench for lcg_random_generator: several parameterisations run side by side
// against an arithmetic reference model of the recurrence.
module tb_lcg_random_generator;

  localparam longint A_TAB [4] = '{64'd1103515245, 64'd1664525, 64'd22695477, 64'd214013};
  localparam longint C_TAB [4] = '{64'd12345, 64'd1013904223, 64'd1, 64'd2531011};

  localparam int SEED_MAIN  = 8;
  localparam int SEED_V1    = 12345;
  localparam int SEED_V2    = 777;
  localparam int SEED_V3    = 300000;
  localparam int SEED_V7    = 8;
  localparam int SEED_SMALL = 0;

  logic clk;
  logic rst;
  logic en_main;
  logic en_sweep;

  int error_count = 0;
  int check_count = 0;

  longint m_main, m_v1, m_v2, m_v3, m_v7, m_small;

  lcg_random_generator_if #(.width_output(8)) if_main  ();
  lcg_random_generator_if #(.width_output(8)) if_v1    ();
  lcg_random_generator_if #(.width_output(8)) if_v2    ();
  lcg_random_generator_if #(.width_output(8)) if_v3    ();
  lcg_random_generator_if #(.width_output(8)) if_v7    ();
  lcg_random_generator_if #(.width_output(4)) if_small ();

  assign if_main.enable  = en_main;
  assign if_v1.enable    = en_sweep;
  assign if_v2.enable    = en_sweep;
  assign if_v3.enable    = en_sweep;
  assign if_v7.enable    = en_sweep;
  assign if_small.enable = en_sweep;

  lcg_random_generator #(.seed(SEED_MAIN), .variant(0), .width_state(18), .width_output(8)) u_main (
    .clk(clk), .rst(rst), .bus(if_main.slave));
  lcg_random_generator #(.seed(SEED_V1), .variant(1), .width_state(18), .width_output(8)) u_v1 (
    .clk(clk), .rst(rst), .bus(if_v1.slave));
  lcg_random_generator #(.seed(SEED_V2), .variant(2), .width_state(18), .width_output(8)) u_v2 (
    .clk(clk), .rst(rst), .bus(if_v2.slave));
  lcg_random_generator #(.seed(SEED_V3), .variant(3), .width_state(18), .width_output(8)) u_v3 (
    .clk(clk), .rst(rst), .bus(if_v3.slave));
  lcg_random_generator #(.seed(SEED_V7), .variant(7), .width_state(18), .width_output(8)) u_v7 (
    .clk(clk), .rst(rst), .bus(if_v7.slave));
  lcg_random_generator #(.seed(SEED_SMALL), .variant(2), .width_state(4), .width_output(4)) u_small (
    .clk(clk), .rst(rst), .bus(if_small.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint lcg_next(longint s, int v, int w);
    longint m;
    m = (64'd1 << w) - 1;
    return (A_TAB[v] * s + C_TAB[v]) & m;
  endfunction

  function automatic longint seed_of(longint s, int w);
    return s & ((64'd1 << w) - 1);
  endfunction

  function automatic longint top_bits(longint s, int w, int wo);
    return s >> (w - wo);
  endfunction

  task automatic check_output(input string tag, input longint observed, input longint expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One clock: inputs are already stable, so the model follows the same rules at the same edge.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
    if (rst) begin
      m_main  = seed_of(SEED_MAIN, 18);
      m_v1    = seed_of(SEED_V1, 18);
      m_v2    = seed_of(SEED_V2, 18);
      m_v3    = seed_of(SEED_V3, 18);
      m_v7    = seed_of(SEED_V7, 18);
      m_small = seed_of(SEED_SMALL, 4);
    end else begin
      if (en_main) m_main = lcg_next(m_main, 0, 18);
      if (en_sweep) begin
        m_v1    = lcg_next(m_v1, 1, 18);
        m_v2    = lcg_next(m_v2, 2, 18);
        m_v3    = lcg_next(m_v3, 3, 18);
        m_v7    = lcg_next(m_v7, 0, 18);
        m_small = lcg_next(m_small, 2, 4);
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_output({tag, "_main"},  longint'(if_main.out),  top_bits(m_main, 18, 8));
    check_output({tag, "_v1"},    longint'(if_v1.out),    top_bits(m_v1, 18, 8));
    check_output({tag, "_v2"},    longint'(if_v2.out),    top_bits(m_v2, 18, 8));
    check_output({tag, "_v3"},    longint'(if_v3.out),    top_bits(m_v3, 18, 8));
    check_output({tag, "_v7"},    longint'(if_v7.out),    top_bits(m_v7, 18, 8));
    check_output({tag, "_small"}, longint'(if_small.out), m_small);
  endtask

  initial begin
    longint period_seq [16];
    longint first_run  [50];
    longint s;
    logic [15:0] seen;

    period_seq = '{0, 1, 6, 15, 12, 13, 2, 11, 8, 9, 14, 7, 4, 5, 10, 3};
    s = SEED_MAIN;
    for (int k = 0; k < 50; k++) begin
      s = lcg_next(s, 0, 18);
      first_run[k] = s >> 10;
    end

    rst = 1'b1; en_main = 1'b0; en_sweep = 1'b0;
    apply_stimulus();
    check_output("reset_out", longint'(if_main.out), 0);
    check_output("reset_small", longint'(if_small.out), 0);
    check_output("reset_v3_trunc", longint'(if_v3.out), 37856 >> 10);
    check_all("reset");

    rst = 1'b0; en_main = 1'b1;
    apply_stimulus();
    check_output("first_step", longint'(if_main.out), 168);
    check_all("first_step");

    en_main = 1'b0;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus();
      check_output("hold", longint'(if_main.out), 168);
    end

    en_main = 1'b1;
    apply_stimulus();
    check_output("resume", longint'(if_main.out), lcg_next(172961, 0, 18) >> 10);

    rst = 1'b1; en_main = 1'b1; en_sweep = 1'b1;
    apply_stimulus();
    check_output("rst_priority", longint'(if_main.out), 0);
    check_all("rst_priority");

    rst = 1'b0;
    seen = 16'h0000;
    for (int i = 0; i < 1000; i++) begin
      en_main = 1'($urandom_range(0, 1));
      apply_stimulus();
      check_all("sweep");
      check_output("period_seq", longint'(if_small.out), period_seq[(i + 1) % 16]);
      if (i < 16) seen[if_small.out] = 1'b1;
      if (i == 15) check_output("period_coverage", longint'(seen), 64'hFFFF);
    end

    rst = 1'b1;
    apply_stimulus();
    rst = 1'b0; en_main = 1'b1;
    for (int k = 0; k < 50; k++) begin
      apply_stimulus();
      check_output("rerun", longint'(if_main.out), first_run[k]);
      check_all("rerun");
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
